// File: rtl/count_display_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit
// multiplexed seven-segment driver; the converted BCD is also exported with a strobe.
module count_display_driver #(
  parameter int CNT_W       = 10,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  output logic [15:0]      bcd_out,
  output logic             bcd_valid,
  output logic             busy,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an
);

  localparam int IW = $clog2(CNT_W + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] ITER_INIT = IW'(CNT_W);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] last_conv_q, last_conv_d;
  logic [15:0]      scratch_q, scratch_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic             force_q, force_d;
  logic             busy_q, busy_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             valid_q, valid_d;
  logic             disp_en_q, disp_en_d;
  logic [RW-1:0]    ref_q, ref_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       digit_s;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [15:0] dd_adjust(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = s[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // A non-units digit is a leading zero when it and every higher digit are zero.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd1:    lz_blank = (v[15:4] == 12'd0);
      2'd2:    lz_blank = (v[15:8] == 8'd0);
      2'd3:    lz_blank = (v[15:12] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
  endfunction

  // Converter FSM: capture in IDLE, CNT_W shift iterations, publish in DONE.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    last_conv_d = last_conv_q;
    scratch_d   = scratch_q;
    iter_d      = iter_q;
    force_d     = force_q;
    busy_d      = busy_q;
    bcd_d       = bcd_q;
    valid_d     = 1'b0;
    disp_en_d   = disp_en_q;
    case (state_q)
      ST_IDLE: begin
        if (force_q || (count_in != last_conv_q)) begin
          shreg_d     = count_in;
          last_conv_d = count_in;
          scratch_d   = 16'd0;
          iter_d      = ITER_INIT;
          busy_d      = 1'b1;
          state_d     = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        {scratch_d, shreg_d} = {dd_adjust(scratch_q), shreg_q} << 1'b1;
        iter_d = iter_q - IW'(1);
        if (iter_q == IW'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        bcd_d     = scratch_q;
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        force_d   = 1'b0;
        disp_en_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Digit-slot timer; runs even before the first conversion has completed.
  always_comb begin
    if (ref_q == REF_LAST) begin
      ref_d = {RW{1'b0}};
      idx_d = idx_q + 2'd1;
    end else begin
      ref_d = ref_q + RW'(1);
      idx_d = idx_q;
    end
  end

  // Select the nibble shown in the current slot.
  always_comb begin
    case (idx_q)
      2'd0:    digit_s = bcd_q[3:0];
      2'd1:    digit_s = bcd_q[7:4];
      2'd2:    digit_s = bcd_q[11:8];
      2'd3:    digit_s = bcd_q[15:12];
      default: digit_s = 4'd0;
    endcase
  end

  // Next segment and anode values, registered below.
  always_comb begin
    if (BLANK_LZ && lz_blank(bcd_q, idx_q)) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = seg_decode(digit_s);
    end
    if (disp_en_q) begin
      an_d = ~(4'b0001 << idx_q);
    end else begin
      an_d = 4'hF;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= {CNT_W{1'b0}};
      last_conv_q <= {CNT_W{1'b0}};
      scratch_q   <= 16'd0;
      iter_q      <= {IW{1'b0}};
      force_q     <= 1'b1;
      busy_q      <= 1'b0;
      bcd_q       <= 16'd0;
      valid_q     <= 1'b0;
      disp_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      last_conv_q <= last_conv_d;
      scratch_q   <= scratch_d;
      iter_q      <= iter_d;
      force_q     <= force_d;
      busy_q      <= busy_d;
      bcd_q       <= bcd_d;
      valid_q     <= valid_d;
      disp_en_q   <= disp_en_d;
    end
  end

  // Refresh timer and display output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_q <= {RW{1'b0}};
      idx_q <= 2'd0;
      seg_q <= 7'h7F;
      an_q  <= 4'hF;
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign bcd_valid = valid_q;
  assign busy      = busy_q;
  assign seg       = seg_q;
  assign an        = an_q;
  assign dp        = 1'b1;

endmodule

// File: tb/tb_count_display_driver.sv
// Randomised + directed bench: a timing-level model predicts which values are
// converted and when; a negedge monitor checks every bcd_valid against the queue.
module tb_count_display_driver;

  localparam int CNT_W       = 10;
  localparam int REFRESH_DIV = 4;
  localparam logic [6:0] GLYPH [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [15:0] bcd;
    int          cap;
    int          due;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [CNT_W-1:0] count_in = '0;
  logic [15:0]      bcd_out, nb_bcd_out;
  logic             bcd_valid, nb_bcd_valid, busy, nb_busy, dp, nb_dp;
  logic [6:0]       seg, nb_seg;
  logic [3:0]       an, nb_an;

  int   n_vec = 0, n_err = 0, n_pulses = 0;
  int   edge_cnt = 0, since_rst = 0;
  exp_t q[$];
  bit   m_force = 1'b1;
  logic [CNT_W-1:0] m_last = '0;
  int   next_ok = 0;

  count_display_driver #(.CNT_W(CNT_W), .REFRESH_DIV(REFRESH_DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .bcd_out(bcd_out),
    .bcd_valid(bcd_valid), .busy(busy), .seg(seg), .dp(dp), .an(an));

  count_display_driver #(.CNT_W(CNT_W), .REFRESH_DIV(REFRESH_DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .count_in(count_in), .bcd_out(nb_bcd_out),
    .bcd_valid(nb_bcd_valid), .busy(nb_busy), .seg(nb_seg), .dp(nb_dp), .an(nb_an));

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) since_rst <= 0;
    else        since_rst <= since_rst + 1;
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Model: the converter accepts a new value only when it is free and the value
  // differs from the last accepted one (or after reset); result is due CNT_W+1 later.
  task automatic predict();
    int e;
    if (!reset) begin
      q.delete();
      m_force = 1'b1;
      next_ok = 0;
    end else begin
      e = edge_cnt + 1;
      if (e >= next_ok && (m_force || count_in != m_last)) begin
        q.push_back('{bcd: to_bcd(int'(count_in)), cap: e, due: e + CNT_W + 1});
        m_last  = count_in;
        m_force = 1'b0;
        next_ok = e + CNT_W + 2;
      end
    end
  endtask

  task automatic drive(input logic [CNT_W-1:0] v, input logic r);
    @(negedge clk);
    reset    = r;
    count_in = v;
    predict();
  endtask

  task automatic hold(input int n);
    repeat (n) drive(count_in, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if (bcd_out !== 16'h0 || bcd_valid !== 1'b0 || busy !== 1'b0 || seg !== 7'h7F ||
        dp !== 1'b1 || an !== 4'hF || nb_bcd_out !== 16'h0 || nb_busy !== 1'b0 ||
        nb_seg !== 7'h7F || nb_an !== 4'hF) begin
      n_err++;
      $display("FAIL %s: bcd=%h valid=%b busy=%b seg=%h dp=%b an=%h nb_seg=%h nb_an=%h, want 0/0/0/7f/1/f",
               tag, bcd_out, bcd_valid, busy, seg, dp, an, nb_seg, nb_an);
    end
  endtask

  task automatic check_display(input logic [15:0] val, input int cycles);
    int k, idx;
    logic [3:0] nib, exp_an;
    logic [6:0] exp_nb, exp_lz;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      k      = since_rst;
      idx    = ((k - 1) / REFRESH_DIV) % 4;
      exp_an = ~(4'b0001 << idx);
      nib    = val[idx*4 +: 4];
      exp_nb = GLYPH[int'(nib)];
      exp_lz = (idx != 0 && (val >> (idx * 4)) == 16'd0) ? 7'h7F : exp_nb;
      n_vec++;
      if (an !== exp_an || seg !== exp_lz || dp !== 1'b1 ||
          nb_an !== exp_an || nb_seg !== exp_nb || nb_dp !== 1'b1) begin
        n_err++;
        $display("FAIL display val=%h slot=%0d: an=%h seg=%h nb_an=%h nb_seg=%h dp=%b%b, want an=%h seg=%h nb_seg=%h dp=11",
                 val, idx, an, seg, nb_an, nb_seg, dp, nb_dp, exp_an, exp_lz, exp_nb);
      end
    end
  endtask

  task automatic check_pulses(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: %0d bcd_valid pulses, want %0d", tag, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on each bcd_valid and tracks busy.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_busy;
    if (bcd_valid) begin
      n_vec++;
      n_pulses++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: bcd=%h at edge %0d, none expected", bcd_out, edge_cnt);
      end else begin
        e = q.pop_front();
        if (bcd_out !== e.bcd || nb_bcd_out !== e.bcd || nb_bcd_valid !== 1'b1 || e.due != edge_cnt) begin
          n_err++;
          $display("FAIL conversion: bcd=%h nb_bcd=%h nb_valid=%b at edge %0d, want %h at edge %0d",
                   bcd_out, nb_bcd_out, nb_bcd_valid, edge_cnt, e.bcd, e.due);
        end
      end
    end else if (q.size() > 0 && q[0].due < edge_cnt) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_valid: no pulse by edge %0d, want %h at edge %0d", edge_cnt, q[0].bcd, q[0].due);
      void'(q.pop_front());
    end
    exp_busy = (q.size() > 0) && (q[0].cap <= edge_cnt);
    if (busy !== exp_busy || nb_busy !== exp_busy) begin
      n_vec++;
      n_err++;
      $display("FAIL busy at edge %0d: busy=%b nb_busy=%b, want %b", edge_cnt, busy, nb_busy, exp_busy);
    end
  end

  initial begin
    int p0;
    logic [CNT_W-1:0] v;

    // Reset held with count_in = 0
    repeat (4) drive(10'd0, 1'b0);
    check_reset_outputs("reset_hold");
    drive(10'd0, 1'b1);
    hold(14);
    check_display(to_bcd(0), 16);

    // 1023 held
    p0 = n_pulses;
    drive(10'd1023, 1'b1);
    hold(14);
    check_pulses("pulse_1023", n_pulses - p0, 1);
    check_display(to_bcd(1023), 16);

    // Stepped 0..12, one change per 20 clocks
    p0 = n_pulses;
    for (int i = 0; i <= 12; i++) begin
      drive(CNT_W'(i), 1'b1);
      hold(19);
    end
    check_pulses("pulse_step", n_pulses - p0, 13);

    // 5 -> 7 -> 9 on consecutive cycles while converting 5
    p0 = n_pulses;
    drive(10'd5, 1'b1);
    drive(10'd7, 1'b1);
    drive(10'd9, 1'b1);
    hold(30);
    check_pulses("pulse_579", n_pulses - p0, 2);

    // Asynchronous reset in the middle of converting 999
    drive(10'd999, 1'b1);
    hold(5);
    @(posedge clk);
    #2;
    reset = 1'b0;
    predict();
    #1;
    check_reset_outputs("async_reset");
    repeat (3) drive(10'd999, 1'b0);
    drive(10'd999, 1'b1);
    hold(14);
    check_display(to_bcd(999), 8);

    // Small value: leading-zero blanking vs. all digits shown
    drive(10'd7, 1'b1);
    hold(14);
    check_display(to_bcd(7), 16);

    // Randomised changes at random intervals
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) v = count_in;
      else                           v = CNT_W'($urandom_range(0, 1023));
      drive(v, 1'b1);
      hold($urandom_range(0, 13));
    end

    // Drain outstanding conversions
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d conversions still outstanding, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
